// File: rtl/rvfi_retire_sequencer.sv
// rvfi_retire_sequencer
//   Serializes up to NRET parallel RVFI retirement channels into a single
//   in-order stream (one entry per cycle) through a DEPTH-entry FIFO. Only the
//   fetch-relevant fields travel: order, insn, trap, pc_rdata, pc_wdata.
//   Also checks that popped rvfi_order values are consecutive (mod 256) and
//   flags dropped retire groups.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   in_valid[NRET]    per-channel retire valid (non-contiguous allowed)
//   in_order/insn/trap/pc_rdata/pc_wdata   per-channel packed fields
//   out_valid/out_ready                    single-channel handshake
//   out_order/insn/trap/pc_rdata/pc_wdata  head entry of the FIFO
//   level             current FIFO occupancy
//   overflow          sticky: a whole retire group was dropped for lack of room
//   order_error       sticky: a popped order differed from the expected one
//   retired_count     number of entries popped (wraps at 2^32)
module rvfi_retire_sequencer #(
    parameter int XLEN  = 32,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRET-1:0]          in_valid,
    input  logic [NRET*8-1:0]        in_order,
    input  logic [NRET*32-1:0]       in_insn,
    input  logic [NRET-1:0]          in_trap,
    input  logic [NRET*XLEN-1:0]     in_pc_rdata,
    input  logic [NRET*XLEN-1:0]     in_pc_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_order,
    output logic [31:0]              out_insn,
    output logic                     out_trap,
    output logic [XLEN-1:0]          out_pc_rdata,
    output logic [XLEN-1:0]          out_pc_wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     order_error,
    output logic [31:0]              retired_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]      mem_order  [DEPTH];
    logic [31:0]     mem_insn   [DEPTH];
    logic            mem_trap   [DEPTH];
    logic [XLEN-1:0] mem_pc_r   [DEPTH];
    logic [XLEN-1:0] mem_pc_w   [DEPTH];

    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [7:0]      expected_order;

    logic            pop;
    logic [LW-1:0]   push_cnt;
    logic [AW-1:0]   slot [NRET];
    logic [LW:0]     free;
    logic            accept;
    logic            drop;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;

    // Head entry straight from storage; forced to zero while empty so the
    // outputs read 0 out of reset.
    assign out_order    = out_valid ? mem_order[rptr] : '0;
    assign out_insn     = out_valid ? mem_insn[rptr]  : '0;
    assign out_trap     = out_valid ? mem_trap[rptr]  : 1'b0;
    assign out_pc_rdata = out_valid ? mem_pc_r[rptr]  : '0;
    assign out_pc_wdata = out_valid ? mem_pc_w[rptr]  : '0;

    // Compaction: each valid channel lands at wptr + (number of valid
    // channels below it), so the queue order follows channel index.
    always_comb begin
        push_cnt = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            slot[i] = wptr + push_cnt[AW-1:0];
            if (in_valid[i]) begin
                push_cnt = push_cnt + LW'(1);
            end
        end
    end

    // A slot freed by this cycle's pop is usable by this cycle's push.
    always_comb begin
        free   = (LW+1)'(DEPTH) - (LW+1)'(level) + (LW+1)'(pop);
        accept = (push_cnt != '0) && ({1'b0, push_cnt} <= free);
        drop   = {1'b0, push_cnt} > free;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < NRET; i++) begin
                if (in_valid[i]) begin
                    mem_order[slot[i]] <= in_order[i*8 +: 8];
                    mem_insn[slot[i]]  <= in_insn[i*32 +: 32];
                    mem_trap[slot[i]]  <= in_trap[i];
                    mem_pc_r[slot[i]]  <= in_pc_rdata[i*XLEN +: XLEN];
                    mem_pc_w[slot[i]]  <= in_pc_wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr           <= '0;
            rptr           <= '0;
            level          <= '0;
            overflow       <= 1'b0;
            order_error    <= 1'b0;
            expected_order <= '0;
            retired_count  <= '0;
        end else begin
            level <= level + (accept ? push_cnt : LW'(0)) - LW'(pop);
            if (accept) begin
                wptr <= wptr + push_cnt[AW-1:0];
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rptr           <= rptr + AW'(1);
                retired_count  <= retired_count + 32'd1;
                // Resynchronize on the observed order so one gap flags once.
                expected_order <= out_order + 8'd1;
                if (out_order != expected_order) begin
                    order_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
module tb_rvfi_retire_sequencer;

    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NRET-1:0]        in_valid = '0;
    logic [NRET*8-1:0]      in_order = '0;
    logic [NRET*32-1:0]     in_insn = '0;
    logic [NRET-1:0]        in_trap = '0;
    logic [NRET*XLEN-1:0]   in_pc_rdata = '0;
    logic [NRET*XLEN-1:0]   in_pc_wdata = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [7:0]             out_order;
    logic [31:0]            out_insn;
    logic                   out_trap;
    logic [XLEN-1:0]        out_pc_rdata;
    logic [XLEN-1:0]        out_pc_wdata;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   order_error;
    logic [31:0]            retired_count;

    rvfi_retire_sequencer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
        .in_trap(in_trap), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_order(out_order), .out_insn(out_insn), .out_trap(out_trap),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .level(level), .overflow(overflow), .order_error(order_error),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ord;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pcr;
        logic [31:0] pcw;
    } ent_t;

    ent_t        sb[$];
    logic [7:0]  m_exp;
    logic        m_err;
    logic        m_ovf;
    logic [31:0] m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [7:0] o);
        ent_t e;
        e.ord  = o;
        e.insn = {4'h0, o, 20'h00013};
        e.trap = o[2] & o[0];
        e.pcr  = 32'h100 + {22'd0, o, 2'b00};
        e.pcw  = e.pcr + 32'd4;
        return e;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_exp = '0;
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_cnt = '0;
    endtask

    task automatic check_state(input string ph);
        chk({ph, ".valid"}, 64'(out_valid), 64'(sb.size() != 0));
        chk({ph, ".level"}, 64'(level), 64'(sb.size()));
        chk({ph, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({ph, ".order_error"}, 64'(order_error), 64'(m_err));
        chk({ph, ".retired"}, 64'(retired_count), 64'(m_cnt));
        if (sb.size() != 0) begin
            chk({ph, ".order"}, 64'(out_order), 64'(sb[0].ord));
            chk({ph, ".insn"}, 64'(out_insn), 64'(sb[0].insn));
            chk({ph, ".trap"}, 64'(out_trap), 64'(sb[0].trap));
            chk({ph, ".pc_rdata"}, 64'(out_pc_rdata), 64'(sb[0].pcr));
            chk({ph, ".pc_wdata"}, 64'(out_pc_wdata), 64'(sb[0].pcw));
        end
    endtask

    // Called at a negedge: drive, check head/state, update model, advance.
    task automatic cycle(input string ph, input logic [1:0] v,
                         input logic [7:0] o0, input logic [7:0] o1, input logic rdy);
        ent_t e0, e1, p;
        int   n, free;
        logic popping;
        e0 = mk(o0);
        e1 = mk(o1);
        in_valid    = v;
        in_order    = {o1, o0};
        in_insn     = {e1.insn, e0.insn};
        in_trap     = {e1.trap, e0.trap};
        in_pc_rdata = {e1.pcr, e0.pcr};
        in_pc_wdata = {e1.pcw, e0.pcw};
        out_ready   = rdy;
        #1;
        check_state(ph);
        popping = (sb.size() != 0) && rdy;
        n    = int'(v[0]) + int'(v[1]);
        free = DEPTH - sb.size() + (popping ? 1 : 0);
        if (popping) begin
            p = sb.pop_front();
            if (p.ord != m_exp) m_err = 1'b1;
            m_exp = p.ord + 8'd1;
            m_cnt = m_cnt + 32'd1;
        end
        if (n > free) begin
            m_ovf = 1'b1;
        end else begin
            if (v[0]) sb.push_back(e0);
            if (v[1]) sb.push_back(e1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_state("reset");
        chk("reset.out_order", 64'(out_order), 64'd0);
        chk("reset.out_pc", 64'(out_pc_rdata), 64'd0);
        reset = 1'b0;

        // Basic ordering
        cycle("basic", 2'b11, 8'd0, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("basic", 2'b00, 8'd0, 8'd0, 1'b1);
        check_state("basic.end");

        // Overflow when full, then full-with-pop admission
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle("fill", 2'b11, 8'(2*i), 8'(2*i+1), 1'b0);
        cycle("ovf", 2'b01, 8'd8, 8'd0, 1'b0);
        cycle("fullpop1", 2'b01, 8'd8, 8'd0, 1'b1);
        cycle("fullpop2", 2'b11, 8'd9, 8'd10, 1'b1);
        for (int i = 0; i < 9; i++) cycle("drain", 2'b00, 8'd0, 8'd0, 1'b1);
        check_state("drain.end");

        // Order gap 0,1,3,4
        do_reset();
        cycle("gap", 2'b11, 8'd0, 8'd1, 1'b0);
        cycle("gap", 2'b11, 8'd3, 8'd4, 1'b1);
        for (int i = 0; i < 5; i++) cycle("gap", 2'b00, 8'd0, 8'd0, 1'b1);
        check_state("gap.end");

        // Long stream through 255 -> 0, mixing channel patterns incl. 2'b10
        do_reset();
        begin
            logic [7:0] o = '0;
            for (int k = 0; k < 200; k++) begin
                if (k % 3 == 0) begin
                    cycle("wrap", 2'b10, 8'd0, o, 1'b1);
                    o = o + 8'd1;
                end else begin
                    cycle("wrap", 2'b11, o, o + 8'd1, 1'b1);
                    o = o + 8'd2;
                end
                if (sb.size() > 4) cycle("wrap", 2'b00, 8'd0, 8'd0, 1'b1);
            end
            for (int i = 0; i < 10; i++) cycle("wrap", 2'b00, 8'd0, 8'd0, 1'b1);
            check_state("wrap.end");

            // Random valid/ready mix; drops create gaps the model tracks
            for (int k = 0; k < 200; k++) begin
                logic [1:0] v;
                v = 2'($urandom_range(0, 3));
                cycle("rand", v, o, o + 8'd1, 1'($urandom_range(0, 1)));
                o = o + 8'd2;
            end
            for (int i = 0; i < 10; i++) cycle("rand", 2'b00, 8'd0, 8'd0, 1'b1);
        end

        // Asynchronous reset mid-stream at level 5
        do_reset();
        cycle("pre", 2'b11, 8'd0, 8'd1, 1'b0);
        cycle("pre", 2'b11, 8'd2, 8'd3, 1'b0);
        cycle("pre", 2'b01, 8'd4, 8'd0, 1'b0);
        check_state("pre5");
        in_valid = '0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_state("async");
        @(negedge clk);
        reset = 1'b0;
        cycle("post", 2'b01, 8'd0, 8'd0, 1'b0);
        cycle("post", 2'b01, 8'd1, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("post", 2'b00, 8'd0, 8'd0, 1'b1);
        check_state("post.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
